// File: rtl/spi_transaction_sequencer.sv
// spi_transaction_sequencer
// Command front end for the SPI master controller. Buffers 1..4 byte write
// commands in a small FIFO, launches them one at a time on the controller,
// collects the received bytes right-aligned and returns one response per
// command. A watchdog guarantees every launched command gets a response.
module spi_transaction_sequencer #(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  // command side
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_data_i,
  input  logic [2:0]  cmd_bytes_i,
  // response side
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic [2:0]  rsp_bytes_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  // SPI master controller side
  output logic        spim_enable_o,
  output logic [31:0] spim_write_data_o,
  output logic [2:0]  spim_bytes_o,
  input  logic        spim_ready_i,
  input  logic [31:0] spim_read_data_i,
  input  logic [2:0]  spim_read_bytes_valid_i,
  // status
  output logic        busy_o
);

  localparam int AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Received bytes arrive packed from [31:24] downward; shift them so the
  // last received byte lands in [7:0] and unused upper bytes read as zero.
  function automatic logic [31:0] align_rx(input logic [31:0] d, input logic [2:0] n);
    logic [31:0] v;
    case (n)
      3'd1:    v = {24'h000000, d[31:24]};
      3'd2:    v = {16'h0000, d[31:16]};
      3'd3:    v = {8'h00, d[31:8]};
      3'd4:    v = d;
      default: v = 32'h00000000;
    endcase
    return v;
  endfunction

  // command FIFO: {bytes, data}
  logic [34:0]   r_mem [CMD_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;

  // sequencer state and registered outputs
  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic          r_spim_enable;
  logic [31:0]   r_spim_wdata;
  logic [2:0]    r_spim_bytes;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_data;
  logic [2:0]    r_rsp_bytes;
  logic          r_rsp_err;
  logic          r_rsp_timeout;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [34:0]   w_head;
  logic [31:0]   w_head_data;
  logic [2:0]    w_head_bytes;
  logic          w_head_legal;
  logic          w_match;

  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push       = cmd_valid_i & ~w_full;
  // Pops only happen from IDLE, so nothing leaves the FIFO while a response
  // is waiting in RESP or a transaction is in flight.
  assign w_pop        = (r_state == S_IDLE) & ~w_empty & spim_ready_i;
  assign w_head       = r_mem[r_rd_ptr[AW-1:0]];
  assign w_head_data  = w_head[31:0];
  assign w_head_bytes = w_head[34:32];
  assign w_head_legal = (w_head_bytes >= 3'd1) && (w_head_bytes <= 3'd4);
  assign w_match      = (spim_read_bytes_valid_i == r_spim_bytes);

  // Command FIFO storage and pointers; push and pop may coincide.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < CMD_DEPTH; i++) begin
        r_mem[i] <= 35'd0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= {cmd_bytes_i, cmd_data_i};
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Transaction sequencer: launch, watch fill level, drain, hand back response.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_spim_enable <= 1'b0;
      r_spim_wdata  <= 32'h00000000;
      r_spim_bytes  <= 3'd0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= 32'h00000000;
      r_rsp_bytes   <= 3'd0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if (w_head_legal) begin
              r_spim_wdata  <= w_head_data;
              r_spim_bytes  <= w_head_bytes;
              r_spim_enable <= 1'b1;
              r_timer       <= '0;
              r_state       <= S_ACTIVE;
            end else begin
              // Illegal count: answer immediately, never touch the controller.
              r_rsp_data    <= 32'h00000000;
              r_rsp_bytes   <= w_head_bytes;
              r_rsp_err     <= 1'b1;
              r_rsp_timeout <= 1'b0;
              r_rsp_valid   <= 1'b1;
              r_state       <= S_RESP;
            end
          end
        end
        S_ACTIVE: begin
          if (w_match) begin
            // A match in the watchdog's last cycle still counts as success.
            r_rsp_data    <= align_rx(spim_read_data_i, r_spim_bytes);
            r_rsp_bytes   <= r_spim_bytes;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_spim_enable <= 1'b0;
            r_state       <= S_DRAIN;
          end else if (r_timer == TIMER_MAX) begin
            r_rsp_data    <= 32'h00000000;
            r_rsp_bytes   <= r_spim_bytes;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b1;
            r_spim_enable <= 1'b0;
            r_state       <= S_DRAIN;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_DRAIN: begin
          r_spim_enable <= 1'b0;
          if (spim_ready_i) begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_spim_enable <= 1'b0;
          r_rsp_valid   <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o       = ~w_full;
  assign busy_o            = (r_state != S_IDLE) | ~w_empty;
  assign rsp_valid_o       = r_rsp_valid;
  assign rsp_data_o        = r_rsp_data;
  assign rsp_bytes_o       = r_rsp_bytes;
  assign rsp_err_o         = r_rsp_err;
  assign rsp_timeout_o     = r_rsp_timeout;
  assign spim_enable_o     = r_spim_enable;
  assign spim_write_data_o = r_spim_wdata;
  assign spim_bytes_o      = r_spim_bytes;

endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// Directed testbench for spi_transaction_sequencer with a small SPI
// controller model (fixed-pattern or loopback read data).
module tb_spi_transaction_sequencer;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] cmd_data_i = 32'h0;
  logic [2:0]  cmd_bytes_i = 3'd0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_data_o;
  logic [2:0]  rsp_bytes_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        spim_enable_o;
  logic [31:0] spim_write_data_o;
  logic [2:0]  spim_bytes_o;
  logic        spim_ready_i = 1'b1;
  logic [31:0] spim_read_data_i = 32'h0;
  logic [2:0]  spim_read_bytes_valid_i = 3'd0;
  logic        busy_o;

  // controller model controls
  logic        m_stall = 1'b0;
  logic        m_never = 1'b0;
  logic        m_loop  = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  int          mcnt = 0;
  int          en_cnt = 0;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [31:0] FD [5] = '{32'h00000011, 32'h00002222, 32'h00333333,
                                     32'h44444444, 32'hA1B2C3D4};
  localparam logic [2:0]  FC [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

  spi_transaction_sequencer #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_i                   (clk),
    .rstn_i                  (rstn_i),
    .cmd_valid_i             (cmd_valid_i),
    .cmd_ready_o             (cmd_ready_o),
    .cmd_data_i              (cmd_data_i),
    .cmd_bytes_i             (cmd_bytes_i),
    .rsp_valid_o             (rsp_valid_o),
    .rsp_ready_i             (rsp_ready_i),
    .rsp_data_o              (rsp_data_o),
    .rsp_bytes_o             (rsp_bytes_o),
    .rsp_err_o               (rsp_err_o),
    .rsp_timeout_o           (rsp_timeout_o),
    .spim_enable_o           (spim_enable_o),
    .spim_write_data_o       (spim_write_data_o),
    .spim_bytes_o            (spim_bytes_o),
    .spim_ready_i            (spim_ready_i),
    .spim_read_data_i        (spim_read_data_i),
    .spim_read_bytes_valid_i (spim_read_bytes_valid_i),
    .busy_o                  (busy_o)
  );

  always #5 clk = ~clk;

  // Controller model: busy while enabled, reports completion three cycles in.
  always @(negedge clk) begin
    if (spim_enable_o === 1'b1) begin
      spim_ready_i = 1'b0;
      if (!m_never) begin
        if (mcnt < 2) begin
          mcnt++;
        end else begin
          spim_read_bytes_valid_i = spim_bytes_o;
          spim_read_data_i = m_loop ? (spim_write_data_o << (8 * (4 - spim_bytes_o))) : m_rdata;
        end
      end
    end else begin
      mcnt = 0;
      spim_read_bytes_valid_i = 3'd0;
      spim_read_data_i = 32'h0;
      spim_ready_i = !m_stall;
    end
  end

  // Count cycles with the controller enabled.
  always @(negedge clk) begin
    if (spim_enable_o === 1'b1) en_cnt++;
  end

  // Offer one command; returns at the negedge after it was accepted.
  task automatic push(input logic [31:0] d, input logic [2:0] b, output logic ok);
    logic acc;
    ok = 1'b0;
    cmd_valid_i = 1'b1;
    cmd_data_i  = d;
    cmd_bytes_i = b;
    for (int i = 0; i < 200; i++) begin
      acc = cmd_ready_o;
      @(negedge clk);
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_valid_i = 1'b0;
  endtask

  // Wait for a response, capture it, and consume it with a one-cycle ready.
  task automatic get_rsp(output logic got, output logic [31:0] d, output logic [2:0] b,
                         output logic e, output logic t);
    got = 1'b0; d = 32'h0; b = 3'd0; e = 1'b0; t = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (rsp_valid_o === 1'b1) begin
        got = 1'b1; d = rsp_data_o; b = rsp_bytes_o; e = rsp_err_o; t = rsp_timeout_o;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rstn_i = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (cmd_ready_o !== 1'b1) begin n_miss++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready_o); end
    n_vec++; if (rsp_valid_o !== 1'b0) begin n_miss++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid_o); end
    n_vec++; if ({rsp_data_o, rsp_bytes_o, rsp_err_o, rsp_timeout_o} !== 37'd0) begin n_miss++; $display("FAIL reset_rsp_fields got %h/%0d/%b/%b want 0", rsp_data_o, rsp_bytes_o, rsp_err_o, rsp_timeout_o); end
    n_vec++; if ({spim_enable_o, spim_write_data_o, spim_bytes_o} !== 36'd0) begin n_miss++; $display("FAIL reset_spim got %b/%h/%0d want 0", spim_enable_o, spim_write_data_o, spim_bytes_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_miss++; $display("FAIL reset_busy got %b want 0", busy_o); end
    rstn_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic ok;
    m_loop = 1'b0; m_rdata = 32'h3C000000;
    push(32'h000000A5, 3'd1, ok);
    n_vec++; if (ok !== 1'b1) begin n_miss++; $display("FAIL single_accept got %b want 1", ok); end
    n_vec++; if (spim_enable_o !== 1'b0) begin n_miss++; $display("FAIL single_en_after_push got %b want 0", spim_enable_o); end
    @(negedge clk);
    n_vec++; if ({spim_enable_o, spim_bytes_o, spim_write_data_o} !== {1'b1, 3'd1, 32'h000000A5}) begin n_miss++; $display("FAIL single_launch got en=%b n=%0d d=%h want 1/1/a5", spim_enable_o, spim_bytes_o, spim_write_data_o); end
    repeat (2) begin
      @(negedge clk);
      n_vec++; if ({spim_enable_o, spim_bytes_o} !== {1'b1, 3'd1}) begin n_miss++; $display("FAIL single_active got en=%b n=%0d want 1/1", spim_enable_o, spim_bytes_o); end
    end
    @(negedge clk);
    n_vec++; if ({spim_enable_o, rsp_valid_o} !== 2'b00) begin n_miss++; $display("FAIL single_en_drop got en=%b v=%b want 0/0", spim_enable_o, rsp_valid_o); end
    @(negedge clk);
    n_vec++; if (rsp_valid_o !== 1'b1) begin n_miss++; $display("FAIL single_rsp_valid got %b want 1", rsp_valid_o); end
    n_vec++; if ({rsp_data_o, rsp_bytes_o, rsp_err_o, rsp_timeout_o} !== {32'h0000003C, 3'd1, 1'b0, 1'b0}) begin n_miss++; $display("FAIL single_rsp got %h/%0d/%b/%b want 3c/1/0/0", rsp_data_o, rsp_bytes_o, rsp_err_o, rsp_timeout_o); end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    n_vec++; if ({rsp_valid_o, busy_o} !== 2'b00) begin n_miss++; $display("FAIL single_consumed got v=%b busy=%b want 0/0", rsp_valid_o, busy_o); end
  endtask

  task automatic test_four;
    logic ok, got, e, t;
    logic [31:0] d;
    logic [2:0] b;
    int seen;
    m_loop = 1'b0; m_rdata = 32'h11223344;
    push(32'hDEADBEEF, 3'd4, ok);
    for (int i = 0; i < 10 && spim_enable_o !== 1'b1; i++) @(negedge clk);
    seen = 0;
    for (int i = 0; i < 50 && spim_enable_o === 1'b1; i++) begin
      seen++;
      n_vec++; if ({spim_write_data_o, spim_bytes_o} !== {32'hDEADBEEF, 3'd4}) begin n_miss++; $display("FAIL four_hold got %h/%0d want deadbeef/4", spim_write_data_o, spim_bytes_o); end
      @(negedge clk);
    end
    n_vec++; if (seen !== 3) begin n_miss++; $display("FAIL four_active_cycles got %0d want 3", seen); end
    get_rsp(got, d, b, e, t);
    n_vec++; if ({got, d, b, e, t} !== {1'b1, 32'h11223344, 3'd4, 1'b0, 1'b0}) begin n_miss++; $display("FAIL four_rsp got %b/%h/%0d/%b/%b want 1/11223344/4/0/0", got, d, b, e, t); end
  endtask

  task automatic test_fifo_full;
    logic ok, got, e, t;
    logic [31:0] d;
    logic [2:0] b;
    m_loop = 1'b1; m_stall = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) push(FD[i], FC[i], ok);
    n_vec++; if (cmd_ready_o !== 1'b1) begin n_miss++; $display("FAIL full_ready_3 got %b want 1", cmd_ready_o); end
    push(FD[3], FC[3], ok);
    n_vec++; if (cmd_ready_o !== 1'b0) begin n_miss++; $display("FAIL full_ready_4 got %b want 0", cmd_ready_o); end
    cmd_valid_i = 1'b1; cmd_data_i = FD[4]; cmd_bytes_i = FC[4];
    repeat (4) @(negedge clk);
    n_vec++; if ({cmd_ready_o, spim_enable_o, busy_o} !== 3'b001) begin n_miss++; $display("FAIL full_held got rdy=%b en=%b busy=%b want 0/0/1", cmd_ready_o, spim_enable_o, busy_o); end
    m_stall = 1'b0;
    push(FD[4], FC[4], ok);
    n_vec++; if (ok !== 1'b1) begin n_miss++; $display("FAIL full_fifth_accept got %b want 1", ok); end
    for (int i = 0; i < 5; i++) begin
      get_rsp(got, d, b, e, t);
      n_vec++; if ({got, d, b, e, t} !== {1'b1, FD[i], FC[i], 1'b0, 1'b0}) begin n_miss++; $display("FAIL full_rsp%0d got %b/%h/%0d/%b/%b want 1/%h/%0d/0/0", i, got, d, b, e, t, FD[i], FC[i]); end
    end
  endtask

  task automatic test_illegal;
    logic ok, got, e, t;
    logic [31:0] d;
    logic [2:0] b;
    int e0;
    m_loop = 1'b1;
    e0 = en_cnt;
    push(32'h00000055, 3'd0, ok);
    n_vec++; if (rsp_valid_o !== 1'b0) begin n_miss++; $display("FAIL illegal_valid_early got %b want 0", rsp_valid_o); end
    push(32'h00000066, 3'd5, ok);
    n_vec++; if (rsp_valid_o !== 1'b1) begin n_miss++; $display("FAIL illegal_valid_after_pop got %b want 1", rsp_valid_o); end
    for (int i = 0; i < 2; i++) begin
      get_rsp(got, d, b, e, t);
      n_vec++; if ({got, d, e, t} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin n_miss++; $display("FAIL illegal_rsp%0d got %b/%h/%b/%b want 1/0/1/0", i, got, d, e, t); end
    end
    n_vec++; if (en_cnt !== e0) begin n_miss++; $display("FAIL illegal_no_enable got %0d want %0d", en_cnt, e0); end
    push(32'h0000BEEF, 3'd2, ok);
    get_rsp(got, d, b, e, t);
    n_vec++; if ({got, d, b, e, t} !== {1'b1, 32'h0000BEEF, 3'd2, 1'b0, 1'b0}) begin n_miss++; $display("FAIL illegal_then_legal got %b/%h/%0d/%b/%b want 1/beef/2/0/0", got, d, b, e, t); end
    n_vec++; if (en_cnt !== e0 + 3) begin n_miss++; $display("FAIL illegal_legal_enable_cycles got %0d want %0d", en_cnt - e0, 3); end
  endtask

  task automatic test_timeout;
    logic ok, got, e, t;
    logic [31:0] d;
    logic [2:0] b;
    int cnt;
    m_loop = 1'b1; m_never = 1'b1;
    push(32'h12345678, 3'd4, ok);
    for (int i = 0; i < 10 && spim_enable_o !== 1'b1; i++) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 100 && spim_enable_o === 1'b1; i++) begin
      cnt++;
      @(negedge clk);
    end
    n_vec++; if (cnt !== 16) begin n_miss++; $display("FAIL timeout_active_cycles got %0d want 16", cnt); end
    get_rsp(got, d, b, e, t);
    n_vec++; if ({got, d, e, t} !== {1'b1, 32'h0, 1'b0, 1'b1}) begin n_miss++; $display("FAIL timeout_rsp got %b/%h/%b/%b want 1/0/0/1", got, d, e, t); end
    m_never = 1'b0;
  endtask

  task automatic test_backpressure_reset;
    logic ok;
    int w;
    m_loop = 1'b1;
    push(32'h0000CAFE, 3'd2, ok);
    push(32'h00000077, 3'd1, ok);
    w = 0;
    for (int i = 0; i < 100 && rsp_valid_o !== 1'b1; i++) begin w++; @(negedge clk); end
    n_vec++; if (rsp_valid_o !== 1'b1) begin n_miss++; $display("FAIL bp_rsp_arrives got %b want 1 after %0d", rsp_valid_o, w); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++; if ({rsp_valid_o, rsp_data_o, rsp_bytes_o, rsp_err_o, rsp_timeout_o, spim_enable_o, busy_o} !== {1'b1, 32'h0000CAFE, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1}) begin n_miss++; $display("FAIL bp_stable%0d got v=%b d=%h n=%0d en=%b want 1/cafe/2/0", i, rsp_valid_o, rsp_data_o, rsp_bytes_o, spim_enable_o); end
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    n_vec++; if ({rsp_valid_o, spim_enable_o} !== 2'b00) begin n_miss++; $display("FAIL bp_release got v=%b en=%b want 0/0", rsp_valid_o, spim_enable_o); end
    @(negedge clk);
    n_vec++; if ({spim_enable_o, spim_write_data_o} !== {1'b1, 32'h00000077}) begin n_miss++; $display("FAIL bp_next_pop got en=%b d=%h want 1/77", spim_enable_o, spim_write_data_o); end
    rstn_i = 1'b0;
    @(negedge clk);
    rstn_i = 1'b1;
    n_vec++; if ({spim_enable_o, rsp_valid_o, cmd_ready_o, busy_o} !== 4'b0010) begin n_miss++; $display("FAIL rst_mid got en=%b v=%b rdy=%b busy=%b want 0/0/1/0", spim_enable_o, rsp_valid_o, cmd_ready_o, busy_o); end
    repeat (10) @(negedge clk);
    n_vec++; if ({spim_enable_o, rsp_valid_o, busy_o} !== 3'b000) begin n_miss++; $display("FAIL rst_quiet got en=%b v=%b busy=%b want 0/0/0", spim_enable_o, rsp_valid_o, busy_o); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_four();
    test_fifo_full();
    test_illegal();
    test_timeout();
    test_backpressure_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog got no finish want finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule
